// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the fetch/execute sequencer.
//   state_e           : sequencer state encoding (also exported for debug)
//   PC_W              : width of the program counter
//   OPC_W             : width of the opcode field (the top bits of an instruction)
//   HALT_OPC_DEFAULT  : default opcode value that stops the sequencer
//   RETIRED_W         : width of the retired-instruction counter
//   pc_at_max()       : true when the PC holds its largest value
package pc_sequencer_pkg;

  localparam int PC_W      = 12;
  localparam int OPC_W     = 4;
  localparam int RETIRED_W = 16;

  localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  // An increment from this value would wrap the PC to zero.
  function automatic logic pc_at_max(input logic [PC_W-1:0] pc);
    return (pc == {PC_W{1'b1}});
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/execute controller. Owns the PC strobes (clear, load, increment),
// fetches one instruction per memory handshake, issues it to the datapath
// and waits for execution to complete before advancing the PC.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin (or restart) a run; only honoured in IDLE/HALT
//   pc_addr           : current PC value fed back from the PC register
//   pc_write_en       : load PC from pc_datain (branch)
//   pc_inc_en         : increment PC
//   pc_clr_en         : clear PC to zero
//   pc_datain         : branch target, zero when pc_write_en is low
//   mem_rd_req        : instruction read request at address pc_addr
//   mem_ack/mem_rdata : read data valid / instruction word
//   instr             : instruction register
//   instr_valid       : one-cycle pulse, instr is new and must be executed
//   exec_done         : datapath finished the current instruction
//   branch_taken      : sampled with exec_done; load target instead of increment
//   branch_target     : sampled with exec_done
//   busy, halted      : status
//   err               : sticky, an increment past the last PC was attempted
//   retired           : completed-instruction count, saturating
//   state_dbg         : current FSM state (state_e encoding)
//
// Handshakes: mem_rd_req is a level held for every FETCH cycle; the
// transfer happens in the cycle where mem_rd_req and mem_ack are both high
// (an ack in the first FETCH cycle counts). mem_ack in any other state is
// ignored. instr_valid is a single-cycle pulse with no back-pressure; the
// datapath reports completion with exec_done, which is only honoured in
// EXEC and acts in the same cycle it is seen.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               N        = 16,
  parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_W-1:0]      pc_addr,
  output logic                 pc_write_en,
  output logic                 pc_inc_en,
  output logic                 pc_clr_en,
  output logic [N-1:0]         pc_datain,
  output logic                 mem_rd_req,
  input  logic                 mem_ack,
  input  logic [N-1:0]         mem_rdata,
  output logic [N-1:0]         instr,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic                 branch_taken,
  input  logic [N-1:0]         branch_target,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [RETIRED_W-1:0] retired,
  output logic [2:0]           state_dbg
);

  state_e state;

  logic is_halt_opc;
  assign is_halt_opc = (instr[N-1 -: OPC_W] == HALT_OPC);

  // Sequencer state, instruction register, error flag, retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instr   <= '0;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLR;
        end
        S_CLR: begin
          retired <= '0;
          err     <= 1'b0;
          state   <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            instr <= mem_rdata;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A halt opcode is never executed, so it neither retires nor
          // moves the PC.
          state <= is_halt_opc ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (retired != {RETIRED_W{1'b1}}) retired <= retired + RETIRED_W'(1);
            if (branch_taken) begin
              state <= S_FETCH;
            end else if (pc_at_max(pc_addr)) begin
              // Refuse to wrap the PC; stop and flag it instead.
              err   <= 1'b1;
              state <= S_HALT;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (start) state <= S_CLR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and strobes decode from the registered state; the EXEC strobes
  // also depend on exec_done so the PC moves on the edge that leaves EXEC.
  // The priority chain keeps the three PC strobes mutually exclusive.
  always_comb begin
    pc_write_en = 1'b0;
    pc_inc_en   = 1'b0;
    pc_clr_en   = 1'b0;
    pc_datain   = '0;
    mem_rd_req  = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state)
      S_CLR: begin
        pc_clr_en = 1'b1;
        busy      = 1'b1;
      end
      S_FETCH: begin
        mem_rd_req = 1'b1;
        busy       = 1'b1;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (exec_done) begin
          if (branch_taken) begin
            pc_write_en = 1'b1;
            pc_datain   = branch_target;
          end else if (!pc_at_max(pc_addr)) begin
            pc_inc_en = 1'b1;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. A behavioural PC register closes the
// pc_addr loop. Instruction words are pushed to exp_q when they are offered
// with mem_ack in FETCH and popped when instr_valid appears.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start;
  logic [PC_W-1:0]      pc_addr;
  logic                 pc_write_en;
  logic                 pc_inc_en;
  logic                 pc_clr_en;
  logic [N-1:0]         pc_datain;
  logic                 mem_rd_req;
  logic                 mem_ack;
  logic [N-1:0]         mem_rdata;
  logic [N-1:0]         instr;
  logic                 instr_valid;
  logic                 exec_done;
  logic                 branch_taken;
  logic [N-1:0]         branch_target;
  logic                 busy;
  logic                 halted;
  logic                 err;
  logic [RETIRED_W-1:0] retired;
  logic [2:0]           state_dbg;

  pc_sequencer #(.N(N), .HALT_OPC(4'hF)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pc_addr       (pc_addr),
    .pc_write_en   (pc_write_en),
    .pc_inc_en     (pc_inc_en),
    .pc_clr_en     (pc_clr_en),
    .pc_datain     (pc_datain),
    .mem_rd_req    (mem_rd_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .busy          (busy),
    .halted        (halted),
    .err           (err),
    .retired       (retired),
    .state_dbg     (state_dbg)
  );

  // PC register model: not reset, only moved by the sequencer's strobes.
  logic [PC_W-1:0] pc_q = 12'h3A5;
  always @(posedge clk) begin
    if (pc_clr_en)        pc_q <= '0;
    else if (pc_write_en) pc_q <= pc_datain[PC_W-1:0];
    else if (pc_inc_en)   pc_q <= pc_q + 12'd1;
  end
  assign pc_addr = pc_q;

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag, input logic wr, input logic inc, input logic clr);
    check({tag, "_wr"},  32'(pc_write_en), 32'(wr));
    check({tag, "_inc"}, 32'(pc_inc_en),   32'(inc));
    check({tag, "_clr"}, 32'(pc_clr_en),   32'(clr));
    if (!wr) check({tag, "_datain0"}, 32'(pc_datain), 32'd0);
  endtask

  task automatic pop_instr(input string tag);
    logic [N-1:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_instr"}, 32'(instr), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well clear of both clock edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_cycles;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_state",   32'(state_dbg), 32'(S_IDLE));
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_halted",  32'(halted),    32'd0);
    check("rst_err",     32'(err),       32'd0);
    check("rst_rdreq",   32'(mem_rd_req), 32'd0);
    check("rst_ivalid",  32'(instr_valid), 32'd0);
    check("rst_instr",   32'(instr),     32'd0);
    check("rst_retired", 32'(retired),   32'd0);
    check_strobes("rst", 1'b0, 1'b0, 1'b0);

    // Free-running loop: ack and exec_done tied high
    start = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1234; exec_done = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("clr_state", 32'(state_dbg), 32'(S_CLR));
    check("clr_busy",  32'(busy), 32'd1);
    check_strobes("clr", 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("loop_fetch_rdreq", 32'(mem_rd_req), 32'd1);
      check("loop_fetch_pc",    32'(pc_addr), 32'(i));
      check("loop_retired",     32'(retired), 32'(i));
      check_strobes("loop_fetch", 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mem_rdata);
      tick();
      settle();
      pop_instr("loop_issue");
      check_strobes("loop_issue", 1'b0, 1'b0, 1'b0);
      tick();
      settle();
      check("loop_exec_state", 32'(state_dbg), 32'(S_EXEC));
      check_strobes("loop_exec", 1'b0, 1'b1, 1'b0);
      tick();
    end

    // Branch
    settle();
    check("br_fetch_pc",  32'(pc_addr), 32'h003);
    check("br_retired",   32'(retired), 32'd3);
    exp_q.push_back(mem_rdata);
    tick();
    branch_taken = 1'b1; branch_target = 16'h0050;
    settle();
    pop_instr("br_issue");
    check_strobes("br_issue", 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    check_strobes("br_exec", 1'b1, 1'b0, 1'b0);
    check("br_datain", 32'(pc_datain), 32'h0050);
    tick();
    branch_taken = 1'b0; mem_rdata = 16'hF000;
    settle();
    check("br_fetch_pc2", 32'(pc_addr), 32'h050);
    check("br_retired2",  32'(retired), 32'd4);
    check_strobes("br_fetch", 1'b0, 1'b0, 1'b0);

    // Halt opcode
    exp_q.push_back(mem_rdata);
    tick();
    settle();
    pop_instr("halt_issue");
    check_strobes("halt_issue", 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    check("halt_halted",  32'(halted), 32'd1);
    check("halt_busy",    32'(busy), 32'd0);
    check("halt_retired", 32'(retired), 32'd4);
    check("halt_ivalid",  32'(instr_valid), 32'd0);
    check_strobes("halt", 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    check("halt_stays",   32'(state_dbg), 32'(S_HALT));
    check("halt_pc",      32'(pc_addr), 32'h050);

    // Restart from HALT, then a fetch with wait states
    start = 1'b1;
    tick();
    start = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    settle();
    check_strobes("restart_clr", 1'b0, 1'b0, 1'b1);
    check("restart_clr_retired", 32'(retired), 32'd4);
    tick();
    rd_cycles = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        mem_ack = 1'b1; mem_rdata = 16'h0ABC; exec_done = 1'b0;
      end else begin
        exec_done = 1'b1;
      end
      settle();
      if (mem_rd_req) rd_cycles++;
      check("ws_state", 32'(state_dbg), 32'(S_FETCH));
      check("ws_pc",    32'(pc_addr), 32'h000);
      check_strobes("ws", 1'b0, 1'b0, 1'b0);
      if (c == 4) exp_q.push_back(mem_rdata);
      tick();
    end
    mem_ack = 1'b0;
    check("ws_rdreq_cycles", 32'(rd_cycles), 32'd5);
    settle();
    pop_instr("ws_issue");
    check("ws_retired", 32'(retired), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    settle();
    check("spur_ack_state", 32'(state_dbg), 32'(S_EXEC));
    check_strobes("spur_ack", 1'b0, 1'b0, 1'b0);
    tick();
    mem_ack = 1'b0;
    settle();
    check("spur_ack_instr", 32'(instr), 32'h0ABC);
    check("exec_wait_state", 32'(state_dbg), 32'(S_EXEC));

    // Overflow: branch to the last PC, then a non-branch completion
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 16'h0FFF;
    settle();
    check_strobes("ovf_br", 1'b1, 1'b0, 1'b0);
    check("ovf_br_datain", 32'(pc_datain), 32'h0FFF);
    tick();
    exec_done = 1'b0; branch_taken = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h0111;
    settle();
    check("ovf_pc", 32'(pc_addr), 32'hFFF);
    exp_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    settle();
    pop_instr("ovf_issue");
    tick();
    exec_done = 1'b1;
    settle();
    check_strobes("ovf_exec", 1'b0, 1'b0, 1'b0);
    check("ovf_err_before", 32'(err), 32'd0);
    tick();
    exec_done = 1'b0;
    settle();
    check("ovf_err",     32'(err), 32'd1);
    check("ovf_halted",  32'(halted), 32'd1);
    check("ovf_retired", 32'(retired), 32'd2);
    check("ovf_pc_held", 32'(pc_addr), 32'hFFF);

    // Restart clears err; reset asserted in EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("rs_clr_err_sticky", 32'(err), 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2345;
    settle();
    check("rs_err_cleared", 32'(err), 32'd0);
    check("rs_pc", 32'(pc_addr), 32'h000);
    exp_q.push_back(mem_rdata);
    tick();
    mem_ack = 1'b0;
    settle();
    pop_instr("rs_issue");
    tick();
    settle();
    check("rs_exec_state", 32'(state_dbg), 32'(S_EXEC));
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1;
    settle();
    check("rs_state",  32'(state_dbg), 32'(S_IDLE));
    check("rs_busy",   32'(busy), 32'd0);
    check("rs_halted", 32'(halted), 32'd0);
    check("rs_rdreq",  32'(mem_rd_req), 32'd0);
    check("rs_ivalid", 32'(instr_valid), 32'd0);
    check("rs_instr",  32'(instr), 32'd0);
    check("rs_err",    32'(err), 32'd0);
    check_strobes("rs", 1'b0, 1'b0, 1'b0);
    tick();
    mem_ack = 1'b0;
    settle();
    check("rs_late_ack_state", 32'(state_dbg), 32'(S_IDLE));
    check("rs_late_ack_instr", 32'(instr), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute controller that sequences the 12-bit program counter register and the instruction memory read port. It owns the PC's write, increment and clear strobes, so the PC never sees two strobes at once. It fetches one instruction per cycle-pair handshake, hands it to the datapath, and waits for execution to finish. It then either increments the PC or loads a branch target.

## Interface

Parameters:
- N, 16, instruction/data width; also the width of the PC load value.
- HALT_OPC, 4'hF, value of instr[N-1:N-4] that stops the sequencer.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE or HALT
- pc_addr  in  12  current PC value, fed back from the PC register
- pc_write_en  out  1  load PC from pc_datain
- pc_inc_en  out  1  increment PC
- pc_clr_en  out  1  clear PC to 0
- pc_datain  out  N  PC load value (branch target)
- mem_rd_req  out  1  instruction read request, address = pc_addr
- mem_ack  in  1  read data valid on mem_rdata
- mem_rdata  in  N  instruction word
- instr  out  N  captured instruction register
- instr_valid  out  1  one-cycle pulse: instr is new and to be executed
- exec_done  in  1  datapath has finished the current instruction
- branch_taken  in  1  sampled with exec_done: load target instead of increment
- branch_target  in  N  sampled with exec_done
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- err  out  1  sticky: PC overflow attempted
- retired  out  16  count of completed instructions, saturating

## Operation

- States: IDLE, CLR, FETCH, ISSUE, EXEC, HALT.
- IDLE: all strobes 0. start=1 -> CLR.
- CLR: pc_clr_en=1 for exactly one cycle; retired<=0, err<=0 -> FETCH.
- FETCH: mem_rd_req=1 (level) until mem_ack. On mem_ack, instr<=mem_rdata -> ISSUE. A mem_ack in the same cycle FETCH is entered is valid.
- ISSUE: instr_valid=1 for one cycle.
  - If instr[N-1:N-4]==HALT_OPC -> HALT, with no PC change and no retire.
  - Otherwise -> EXEC.
- EXEC: wait for exec_done. On exec_done (Mealy, same cycle), retired increments and saturates at 16'hFFFF:
  - branch_taken=1: pc_write_en=1, pc_datain=branch_target -> FETCH.
  - branch_taken=0, pc_addr!=12'hFFF: pc_inc_en=1 -> FETCH.
  - branch_taken=0, pc_addr==12'hFFF: no strobe, err<=1 -> HALT. The PC never wraps silently.
- HALT: halted=1. start=1 -> CLR, which restarts the run.
- At most one of pc_write_en / pc_inc_en / pc_clr_en is high in any cycle.
- The following are ignored:
  - start while busy.
  - mem_ack outside FETCH.
  - exec_done outside EXEC.
- pc_datain is 0 whenever pc_write_en=0.

## Timing

- Reset values: state IDLE; all strobes, mem_rd_req, instr_valid, busy, halted and err are 0; instr=0; retired=0. The PC register itself is not reset by rst; it is cleared only via CLR.
- rst mid-run: next state is IDLE and all outputs drop the same edge. An outstanding memory request is abandoned, and a late mem_ack is ignored.
- start at edge k: CLR during cycle k+1, FETCH from k+2.
- Minimum loop with a zero-wait mem_ack and exec_done high on EXEC entry is 3 cycles per instruction (FETCH, ISSUE, EXEC).
- PC strobes are combinational from state and inputs. The PC updates on the edge ending EXEC, so pc_addr is valid in the first FETCH cycle.

## Structure

- Shared package: the state enum, PC_W=12, the default HALT_OPC, the opcode field position (top 4 bits), and RETIRED_W=16.
- Single module with the FSM, instruction register, err flag and retired counter. No sub-module is warranted; the opcode compare is one line.

## Test plan

- Reset, then start with mem_ack tied high, mem_rdata=16'h1234 and exec_done tied high, branch_taken=0.
  - pc_clr_en pulses once, then pc_inc_en every 3rd cycle.
  - retired counts 1,2,3…
- Branch: exec_done with branch_taken=1 and branch_target=16'h0050.
  - pc_write_en=1 and pc_datain=16'h0050 for one cycle; the next FETCH shows pc_addr=12'h050.
- Halt: the fetched word 16'hF000 gives instr_valid, then halted=1, with no PC strobe and retired unchanged.
  - A following start gives a CLR pulse and the run resumes.
- Overflow: pc_addr=12'hFFF and a non-branch exec_done give no pc_inc_en, err=1 and halted=1.
- Wait states: mem_ack delayed 5 cycles holds mem_rd_req high for 5 cycles.
  - Spurious exec_done/mem_ack in other states has no effect.
  - rst asserted in EXEC gives IDLE and all outputs 0 the next cycle.
